// File: rtl/alu_issue_stage.sv
// Operand issue stage ahead of the ALU: 2-entry skid buffer with operand forwarding.
// MAIN drives the registered ALU outputs; SKID holds the op accepted while MAIN stalls.
module alu_issue_stage #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CTRL_WIDTH  = 5,
    parameter int unsigned SHAMT_WIDTH = 5,
    parameter int unsigned TAG_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [DATA_WIDTH-1:0]   opA,
    input  logic [DATA_WIDTH-1:0]   opB,
    input  logic [TAG_WIDTH-1:0]    tagA,
    input  logic [TAG_WIDTH-1:0]    tagB,
    input  logic [CTRL_WIDTH-1:0]   ctrlIn,
    input  logic [SHAMT_WIDTH-1:0]  shamtIn,
    input  logic                    fwdValid,
    input  logic [TAG_WIDTH-1:0]    fwdTag,
    input  logic [DATA_WIDTH-1:0]   fwdData,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [2*DATA_WIDTH-1:0] dataIn,
    output logic [CTRL_WIDTH-1:0]   ctrl,
    output logic [SHAMT_WIDTH-1:0]  shamt,
    output logic [CNT_WIDTH-1:0]    stallCount
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  a;
        logic [DATA_WIDTH-1:0]  b;
        logic [TAG_WIDTH-1:0]   tag_a;
        logic [TAG_WIDTH-1:0]   tag_b;
        logic [CTRL_WIDTH-1:0]  ctrl;
        logic [SHAMT_WIDTH-1:0] shamt;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    entry_t                 r_main;
    entry_t                 r_skid;
    entry_t                 w_main_next;
    entry_t                 w_skid_next;
    entry_t                 w_in_entry;
    entry_t                 w_in_fwd;
    entry_t                 w_main_fwd;
    entry_t                 w_skid_fwd;
    logic                   r_out_valid;
    logic [CNT_WIDTH-1:0]   r_stall;
    logic                   w_accept;
    logic                   w_issue;
    logic                   w_fwd_en;

    // Replace each operand whose source tag matches the forwarded destination tag.
    function automatic entry_t fwd_apply(input entry_t e, input logic en,
                                         input logic [TAG_WIDTH-1:0] t,
                                         input logic [DATA_WIDTH-1:0] d);
        entry_t r;
        r = e;
        if (en && (e.tag_a == t)) r.a = d;
        if (en && (e.tag_b == t)) r.b = d;
        return r;
    endfunction

    assign inReady  = (r_state != FULL) && !rst;
    assign w_accept = inValid && inReady;
    assign w_issue  = r_out_valid && outReady;
    assign w_fwd_en = fwdValid && (fwdTag != '0);

    assign w_in_entry = '{a: opA, b: opB, tag_a: tagA, tag_b: tagB,
                          ctrl: ctrlIn, shamt: shamtIn};
    assign w_in_fwd   = fwd_apply(w_in_entry, w_fwd_en, fwdTag, fwdData);
    assign w_main_fwd = fwd_apply(r_main, w_fwd_en, fwdTag, fwdData);
    assign w_skid_fwd = fwd_apply(r_skid, w_fwd_en, fwdTag, fwdData);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_next = ONE;
            ONE: begin
                if (w_accept && !w_issue)      w_state_next = FULL;
                else if (!w_accept && w_issue) w_state_next = EMPTY;
            end
            FULL:    if (w_issue) w_state_next = ONE;
            default: w_state_next = EMPTY;
        endcase
    end

    // Entry next values; an entry leaving this cycle is not forwarded into.
    always_comb begin
        w_main_next = r_main;
        w_skid_next = r_skid;
        case (r_state)
            EMPTY: if (w_accept) w_main_next = w_in_fwd;
            ONE: begin
                if (w_issue) begin
                    if (w_accept) w_main_next = w_in_fwd;
                end else begin
                    w_main_next = w_main_fwd;
                    if (w_accept) w_skid_next = w_in_fwd;
                end
            end
            FULL: begin
                if (w_issue) begin
                    w_main_next = w_skid_fwd;
                end else begin
                    w_main_next = w_main_fwd;
                    w_skid_next = w_skid_fwd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_stall     <= '0;
        end else begin
            r_main      <= w_main_next;
            r_skid      <= w_skid_next;
            r_out_valid <= (w_state_next != EMPTY);
            if (r_out_valid && !outReady && (r_stall != '1))
                r_stall <= r_stall + CNT_WIDTH'(1);
        end
    end

    assign outValid   = r_out_valid;
    assign dataIn     = {r_main.b, r_main.a};
    assign ctrl       = r_main.ctrl;
    assign shamt      = r_main.shamt;
    assign stallCount = r_stall;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: handshake, FIFO order, forwarding, reset and stall saturation.
module tb_alu_issue_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned SW = 5;
    localparam int unsigned TW = 5;
    localparam int unsigned NW = 4;

    logic            clk;
    logic            rst;
    logic            inValid;
    logic            inReady;
    logic [DW-1:0]   opA;
    logic [DW-1:0]   opB;
    logic [TW-1:0]   tagA;
    logic [TW-1:0]   tagB;
    logic [CW-1:0]   ctrlIn;
    logic [SW-1:0]   shamtIn;
    logic            fwdValid;
    logic [TW-1:0]   fwdTag;
    logic [DW-1:0]   fwdData;
    logic            outValid;
    logic            outReady;
    logic [2*DW-1:0] dataIn;
    logic [CW-1:0]   ctrl;
    logic [SW-1:0]   shamt;
    logic [NW-1:0]   stallCount;

    int n_vec;
    int n_err;

    alu_issue_stage #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SHAMT_WIDTH(SW),
        .TAG_WIDTH(TW), .CNT_WIDTH(NW)
    ) u_dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .opA(opA), .opB(opB), .tagA(tagA), .tagB(tagB),
        .ctrlIn(ctrlIn), .shamtIn(shamtIn),
        .fwdValid(fwdValid), .fwdTag(fwdTag), .fwdData(fwdData),
        .outValid(outValid), .outReady(outReady), .dataIn(dataIn),
        .ctrl(ctrl), .shamt(shamt), .stallCount(stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                          input logic [CW-1:0] c, input logic [SW-1:0] s);
        inValid = 1'b1;
        opA = a; opB = b; tagA = ta; tagB = tb; ctrlIn = c; shamtIn = s;
    endtask

    task automatic fwd(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        fwdValid = v; fwdTag = t; fwdData = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inValid = 1'b0; outReady = 1'b0;
        opA = '0; opB = '0; tagA = '0; tagB = '0; ctrlIn = '0; shamtIn = '0;
        fwd(1'b0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;

        // Reset state and single-op latency
        do_reset();
        check("rst_outValid", 64'(outValid), 64'd0);
        check("rst_dataIn", dataIn, 64'd0);
        check("rst_stall", 64'(stallCount), 64'd0);
        check("rst_inReady", 64'(inReady), 64'd1);
        outReady = 1'b1;
        set_op(32'd5, 32'd3, 5'd0, 5'd0, 5'd2, 5'd0);
        tick();
        inValid = 1'b0;
        check("t1_valid", 64'(outValid), 64'd1);
        check("t1_data", dataIn, 64'h00000003_00000005);
        check("t1_ctrl", 64'(ctrl), 64'd2);
        tick();
        check("t1_drain", 64'(outValid), 64'd0);
        check("t1_hold", dataIn, 64'h00000003_00000005);
        check("t1_stall", 64'(stallCount), 64'd0);

        // Back-to-back ops under backpressure, FIFO drain
        do_reset();
        set_op(32'h11, 32'h12, 5'd0, 5'd0, 5'd1, 5'd1);
        tick();
        set_op(32'h21, 32'h22, 5'd0, 5'd0, 5'd3, 5'd2);
        check("t2_rdyY", 64'(inReady), 64'd1);
        tick();
        set_op(32'h31, 32'h32, 5'd0, 5'd0, 5'd4, 5'd7);
        check("t2_rdyZ", 64'(inReady), 64'd0);
        tick();
        check("t2_full", 64'(inReady), 64'd0);
        check("t2_X", dataIn, 64'h00000012_00000011);
        outReady = 1'b1;
        tick();
        check("t2_Y", dataIn, 64'h00000022_00000021);
        check("t2_Yctrl", 64'(ctrl), 64'd3);
        tick();
        inValid = 1'b0;
        check("t2_Z", dataIn, 64'h00000032_00000031);
        check("t2_Zshamt", 64'(shamt), 64'd7);
        tick();
        check("t2_empty", 64'(outValid), 64'd0);
        check("t2_stall", 64'(stallCount), 64'd2);

        // Forwarding at capture, both operands
        do_reset();
        set_op(32'd1, 32'd2, 5'd7, 5'd7, 5'd0, 5'd0);
        fwd(1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();
        inValid = 1'b0;
        fwd(1'b0, '0, '0);
        check("t3_both", dataIn, 64'hDEADBEEF_DEADBEEF);
        outReady = 1'b1;
        tick();

        // Forwarding into held MAIN and SKID entries
        outReady = 1'b0;
        set_op(32'd10, 32'd11, 5'd1, 5'd2, 5'd0, 5'd0);
        tick();
        set_op(32'd20, 32'd21, 5'd3, 5'd4, 5'd0, 5'd0);
        tick();
        inValid = 1'b0;
        fwd(1'b1, 5'd4, 32'd9);
        tick();
        fwd(1'b0, '0, '0);
        check("t4_main_nomatch", dataIn, {32'd11, 32'd10});
        fwd(1'b1, 5'd1, 32'd77);
        tick();
        fwd(1'b0, '0, '0);
        check("t4_main_fwdA", dataIn, {32'd11, 32'd77});
        outReady = 1'b1;
        tick();
        check("t4_skid_fwdB", dataIn, {32'd9, 32'd20});
        tick();
        check("t4_empty", 64'(outValid), 64'd0);

        outReady = 1'b0;
        set_op(32'd10, 32'd11, 5'd1, 5'd2, 5'd0, 5'd0);
        tick();
        set_op(32'd20, 32'd21, 5'd3, 5'd0, 5'd0, 5'd0);
        tick();
        inValid = 1'b0;
        fwd(1'b1, 5'd0, 32'd9);
        tick();
        fwd(1'b0, '0, '0);
        outReady = 1'b1;
        tick();
        check("t4_tag0", dataIn, {32'd21, 32'd20});
        tick();

        outReady = 1'b0;
        set_op(32'd10, 32'd11, 5'd1, 5'd2, 5'd0, 5'd0);
        tick();
        set_op(32'd30, 32'd31, 5'd3, 5'd4, 5'd0, 5'd0);
        tick();
        inValid = 1'b0;
        outReady = 1'b1;
        fwd(1'b1, 5'd4, 32'h55);
        tick();
        fwd(1'b0, '0, '0);
        check("t4_move_fwd", dataIn, {32'h55, 32'd30});
        tick();

        // Asynchronous reset while FULL
        do_reset();
        set_op(32'd1, 32'd2, 5'd0, 5'd0, 5'd1, 5'd0);
        tick();
        set_op(32'd3, 32'd4, 5'd0, 5'd0, 5'd1, 5'd0);
        tick();
        inValid = 1'b0;
        check("t5_full", 64'(inReady), 64'd0);
        rst = 1'b1;
        #1;
        check("t5_async_valid", 64'(outValid), 64'd0);
        check("t5_rst_ready", 64'(inReady), 64'd0);
        check("t5_rst_data", dataIn, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_rel_ready", 64'(inReady), 64'd1);
        outReady = 1'b1;
        tick();
        check("t5_dropped", 64'(outValid), 64'd0);

        // Stall counter saturation
        do_reset();
        set_op(32'hA, 32'hB, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        inValid = 1'b0;
        repeat (5) tick();
        check("t6_stall5", 64'(stallCount), 64'd5);
        repeat (16) tick();
        check("t6_sat", 64'(stallCount), 64'd15);
        check("t6_held", dataIn, {32'hB, 32'hA});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
